dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO window (cycle counter, GPIO, timer).
// Timer block is built only when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_responder #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] addr_mem,
   input  logic [31:0] data_mem,
   input  logic        mem_write,
   output logic [31:0] mem_data,
   output logic [31:0] o_gpio,
   output logic        o_irq
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;

   localparam logic [1:0] SEL_CYCLE = 2'd0;
   localparam logic [1:0] SEL_GPIO  = 2'd1;
   localparam logic [1:0] SEL_COUNT = 2'd2;
   localparam logic [1:0] SEL_CTRL  = 2'd3;

   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] widx;
   logic          in_ram;
   logic          in_mmio;
   logic [1:0]    rsel;
   logic [31:0]   cycle_q;
   logic [31:0]   gpio_q;
   logic [31:0]   tmr_count_rd;
   logic [31:0]   tmr_ctrl_rd;

   assign widx    = addr_mem[AW+1:2];
   assign in_ram  = addr_mem < RAM_BYTES;
   assign in_mmio = (addr_mem[31:4] == MMIO_BASE[31:4]);
   assign rsel    = addr_mem[3:2];

   // RAM is never cleared; a write coinciding with reset is simply dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (resetn && mem_write && in_ram)
         ram[widx] <= data_mem;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle_q <= '0;
         gpio_q  <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (mem_write && in_mmio && rsel == SEL_GPIO)
            gpio_q <= data_mem;
      end
   end

   assign o_gpio = gpio_q;

`ifdef DMEM_RESPONDER_TIMER_EN
   typedef enum logic {IDLE, RUN} tstate_t;

   tstate_t     state_q, state_d;
   logic [31:0] count_q, count_d;
   logic [31:0] reload_q, reload_d;
   logic        auto_q, auto_d;
   logic        pend_q, pend_d;
   logic        wr_count, wr_ctrl;
   logic        expire;

   assign wr_count = mem_write && in_mmio && rsel == SEL_COUNT;
   assign wr_ctrl  = mem_write && in_mmio && rsel == SEL_CTRL;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         auto_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         auto_q   <= auto_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      auto_d   = auto_q;
      pend_d   = pend_q;
      expire   = 1'b0;
      if (state_q == RUN) begin
         if (count_q == 32'd0) begin
            // a load of TIMER_COUNT on this edge masks the expiry
            if (!wr_count) begin
               expire = 1'b1;
               pend_d = 1'b1;
               if (auto_q) count_d = reload_q;
               else        state_d = IDLE;
            end
         end else begin
            count_d = count_q - 32'd1;
         end
      end
      if (wr_count) begin
         count_d  = data_mem;
         reload_d = data_mem;
      end
      if (wr_ctrl) begin
         state_d = data_mem[0] ? RUN : IDLE;
         auto_d  = data_mem[1];
         // expiry beats a simultaneous W1C
         if (data_mem[2] && !expire) pend_d = 1'b0;
      end
   end

   assign tmr_count_rd = count_q;
   assign tmr_ctrl_rd  = {29'd0, pend_q, auto_q, state_q == RUN};
   assign o_irq        = pend_q;
`else
   assign tmr_count_rd = 32'd0;
   assign tmr_ctrl_rd  = 32'd0;
   assign o_irq        = 1'b0;
`endif

   always_comb begin
      mem_data = 32'd0;
      if (in_ram) begin
         mem_data = ram[widx];
      end else if (in_mmio) begin
         case (rsel)
            SEL_CYCLE: mem_data = cycle_q;
            SEL_GPIO:  mem_data = gpio_q;
            SEL_COUNT: mem_data = tmr_count_rd;
            SEL_CTRL:  mem_data = tmr_ctrl_rd;
            default:   mem_data = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; timer checks follow DMEM_RESPONDER_TIMER_EN.
module tb_dmem_responder;

   localparam logic [31:0] MB = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] addr_mem, data_mem, mem_data, o_gpio;
   logic        mem_write, o_irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } sb_t;

   sb_t sb[$];
   sb_t obs[$];

   dmem_responder dut (
      .clk(clk), .resetn(resetn), .addr_mem(addr_mem), .data_mem(data_mem),
      .mem_write(mem_write), .mem_data(mem_data), .o_gpio(o_gpio), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step();
      addr_mem = a; data_mem = d; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
   endtask

   task automatic expect_val(input string n, input logic [31:0] e, input logic [31:0] g);
      sb.push_back('{n, e});
      obs.push_back('{n, g});
   endtask

   task automatic rd(input logic [31:0] a, input string n, input logic [31:0] e);
      addr_mem = a;
      #1;
      expect_val(n, e, mem_data);
   endtask

   task automatic test_reset();
      sb_t e, g;
      resetn = 1'b0; mem_write = 1'b0; addr_mem = '0; data_mem = '0;
      #2;
      expect_val("rst_gpio_port", 32'd0, o_gpio);
      expect_val("rst_irq_port", 32'd0, {31'd0, o_irq});
      rd(MB, "rst_cycle", 32'd0);
      rd(MB + 32'h4, "rst_gpio_rd", 32'd0);
      step(); step();
      resetn = 1'b1;
      step();
      rd(MB, "cycle_first", 32'd1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask

   task automatic test_ram();
      sb_t e, g;
      wr(32'h14, 32'h1234_5678);
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, "ram_10", 32'hDEAD_BEEF);
      rd(32'h13, "ram_13_lowbits", 32'hDEAD_BEEF);
      rd(32'h14, "ram_14_kept", 32'h1234_5678);
      wr(32'd4092, 32'h0000_00A1);
      rd(32'd4092, "ram_top", 32'h0000_00A1);
      wr(32'h0, 32'h5A5A_5A5A);
      wr(32'd4096, 32'hFFFF_FFFF);
      rd(32'd4096, "ram_past_end", 32'd0);
      rd(32'h0, "ram_no_alias", 32'h5A5A_5A5A);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      sb_t e, g;
      step();
      addr_mem = 32'h20; data_mem = 32'd1; mem_write = 1'b1;
      step(); #1;
      expect_val("b2b_ram_1", 32'd1, mem_data);
      data_mem = 32'd2;
      step(); #1;
      expect_val("b2b_ram_2", 32'd2, mem_data);
      addr_mem = MB + 32'h4; data_mem = 32'h11;
      step(); #1;
      expect_val("b2b_gpio_1", 32'h11, o_gpio);
      data_mem = 32'h22;
      step(); #1;
      mem_write = 1'b0;
      expect_val("b2b_gpio_2", 32'h22, o_gpio);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask

   task automatic test_cycle();
      sb_t e, g;
      logic [31:0] c0;
      step();
      addr_mem = MB; #1;
      c0 = mem_data;
      repeat (5) step();
      rd(MB, "cycle_delta5", c0 + 32'd5);
      wr(MB, 32'd0);
      rd(MB, "cycle_wr_ignored", c0 + 32'd7);
      step();
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      rd(MB, "cycle_pre_wrap", 32'hFFFF_FFFE);
      step();
      rd(MB, "cycle_max", 32'hFFFF_FFFF);
      step();
      rd(MB, "cycle_wrap0", 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask

`ifdef DMEM_RESPONDER_TIMER_EN
   task automatic test_timer();
      sb_t e, g;
      logic [31:0] cnt_exp [4];
      logic [31:0] irq_exp [4];
      cnt_exp = '{32'd2, 32'd1, 32'd0, 32'd0};
      irq_exp = '{32'd0, 32'd0, 32'd0, 32'd1};
      // one-shot: load 3, enable
      wr(MB + 32'h8, 32'd3);
      rd(MB + 32'h8, "tmr_load", 32'd3);
      addr_mem = MB + 32'hC; data_mem = 32'd1; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      rd(MB + 32'h8, "tmr_start_cnt", 32'd3);
      rd(MB + 32'hC, "tmr_start_ctrl", 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         rd(MB + 32'h8, $sformatf("tmr_cnt%0d", i), cnt_exp[i]);
         expect_val($sformatf("tmr_irq%0d", i), irq_exp[i], {31'd0, o_irq});
      end
      rd(MB + 32'hC, "tmr_ctrl_expired", 32'h4);
      wr(MB + 32'hC, 32'h4);
      expect_val("tmr_w1c_irq", 32'd0, {31'd0, o_irq});
      // auto-reload: 2 -> expiries every 3 edges
      wr(MB + 32'h8, 32'd2);
      addr_mem = MB + 32'hC; data_mem = 32'd3; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      rd(MB + 32'h8, "ar_cnt_a", 32'd2);
      step(); rd(MB + 32'h8, "ar_cnt_b", 32'd1);
      step(); rd(MB + 32'h8, "ar_cnt_c", 32'd0);
      expect_val("ar_irq_pre", 32'd0, {31'd0, o_irq});
      step(); rd(MB + 32'h8, "ar_reload", 32'd2);
      expect_val("ar_irq_1", 32'd1, {31'd0, o_irq});
      addr_mem = MB + 32'hC; data_mem = 32'd7; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      rd(MB + 32'h8, "ar_cnt_d", 32'd1);
      expect_val("ar_irq_cleared", 32'd0, {31'd0, o_irq});
      step(); rd(MB + 32'h8, "ar_cnt_e", 32'd0);
      // W1C lands on the expiry edge: set must win
      addr_mem = MB + 32'hC; data_mem = 32'd4; mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      expect_val("ar_set_wins_irq", 32'd1, {31'd0, o_irq});
      rd(MB + 32'hC, "ar_set_wins_ctrl", 32'h4);
      step();
      rd(MB + 32'h8, "ar_idle_hold", 32'd2);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask
`else
   task automatic test_no_timer();
      sb_t e, g;
      wr(MB + 32'h8, 32'd3);
      wr(MB + 32'hC, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         rd(MB + 32'h8, $sformatf("nt_cnt%0d", i), 32'd0);
         rd(MB + 32'hC, $sformatf("nt_ctrl%0d", i), 32'd0);
         expect_val($sformatf("nt_irq%0d", i), 32'd0, {31'd0, o_irq});
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask
`endif

   task automatic test_gpio_reset();
      sb_t e, g;
      wr(MB + 32'h4, 32'h0000_00A5);
      expect_val("gpio_a5", 32'h0000_00A5, o_gpio);
      wr(32'h40, 32'hCAFE_0001);
      step();
      addr_mem = 32'h40; data_mem = 32'hBAD0_BAD0; mem_write = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      expect_val("gpio_async_clr", 32'd0, o_gpio);
      expect_val("ram_rd_in_rst", 32'hCAFE_0001, mem_data);
      step();
      mem_write = 1'b0;
      resetn = 1'b1;
      rd(32'h40, "ram_wr_abandoned", 32'hCAFE_0001);
      rd(MB + 32'h20, "unmapped_rd", 32'd0);
      wr(MB + 32'h20, 32'hFFFF_FFFF);
      rd(MB + 32'h20, "unmapped_wr", 32'd0);
      rd(MB + 32'h4, "gpio_after_rst", 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); g = obs.pop_front(); total++;
         if (g.val !== e.val) begin
            bad++; $display("FAIL %s: got=%h want=%h", e.name, g.val, e.val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_back_to_back();
      test_cycle();
`ifdef DMEM_RESPONDER_TIMER_EN
      test_timer();
`else
      test_no_timer();
`endif
      test_gpio_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
